// File: rtl/wb_soc_pkg.sv
// Shared SoC bus definitions: arbiter state encoding, grant codes and master identifiers.
// The state encoding equals the grant code, so the grant output is a direct image of the state.
package wb_soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10,
    ST_ABORT = 2'b11
  } arb_state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_INSN  = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;
  localparam logic [1:0] GNT_ABORT = 2'b11;

  localparam logic LAST_INSN = 1'b0;
  localparam logic LAST_DATA = 1'b1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic logic [1:0] gnt_code(input arb_state_t st);
    logic [1:0] code;
    case (st)
      ST_IDLE:  code = GNT_NONE;
      ST_GNT_I: code = GNT_INSN;
      ST_GNT_D: code = GNT_DATA;
      ST_ABORT: code = GNT_ABORT;
      default:  code = GNT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts cycles a strobe goes unanswered and flags the last permitted one.
// The count saturates at its limit so it can never wrap back to zero.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned     CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Stall cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (run && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = run && (r_count == LIMIT);

endmodule

// File: rtl/wb_cpu_bus_arbiter.sv
// Two-master (instruction/data) Wishbone arbiter onto a single slave port, with
// alternating tie-break, unsplittable tenures and a stall watchdog that aborts a hung slave.
module wb_cpu_bus_arbiter
  import wb_soc_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] ci_adr_i,
  input  logic [DATA_WIDTH-1:0]    ci_dat_i,
  input  logic [3:0]               ci_sel_i,
  input  logic                     ci_we_i,
  input  logic                     ci_cyc_i,
  input  logic                     ci_stb_i,
  input  logic [2:0]               ci_cti_i,
  output logic                     ci_ack_o,
  output logic                     ci_err_o,
  input  logic [ADDRESS_WIDTH-1:0] cd_adr_i,
  input  logic [DATA_WIDTH-1:0]    cd_dat_i,
  input  logic [3:0]               cd_sel_i,
  input  logic                     cd_we_i,
  input  logic                     cd_cyc_i,
  input  logic                     cd_stb_i,
  input  logic [2:0]               cd_cti_i,
  output logic                     cd_ack_o,
  output logic                     cd_err_o,
  output logic [DATA_WIDTH-1:0]    m_dat_o,
  output logic [ADDRESS_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic [2:0]               s_cti_o,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [1:0]               gnt_o
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_gnt;
  logic [1:0] r_gnt;
  logic       w_aborted_cyc;
  logic       w_stb;
  logic       w_run;
  logic       w_clr;
  logic       w_expired;

  // In ABORT the last granted master is the one whose tenure was cut short.
  assign w_aborted_cyc = (r_last_gnt == LAST_INSN) ? ci_cyc_i : cd_cyc_i;

  // Arbitration and tenure tracking.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ci_cyc_i && cd_cyc_i) begin
          w_next_state = (r_last_gnt == LAST_INSN) ? ST_GNT_D : ST_GNT_I;
        end else if (ci_cyc_i) begin
          w_next_state = ST_GNT_I;
        end else if (cd_cyc_i) begin
          w_next_state = ST_GNT_D;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GNT_I: begin
        if (!ci_cyc_i) begin
          w_next_state = ST_IDLE;
        end else if (w_expired) begin
          w_next_state = ST_ABORT;
        end else begin
          w_next_state = ST_GNT_I;
        end
      end
      ST_GNT_D: begin
        if (!cd_cyc_i) begin
          w_next_state = ST_IDLE;
        end else if (w_expired) begin
          w_next_state = ST_ABORT;
        end else begin
          w_next_state = ST_GNT_D;
        end
      end
      ST_ABORT: begin
        if (!w_aborted_cyc) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_ABORT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, tie-break memory and registered grant code.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= LAST_INSN;
      r_gnt      <= GNT_NONE;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= gnt_code(w_next_state);
      if ((r_state == ST_IDLE) && (w_next_state == ST_GNT_I)) begin
        r_last_gnt <= LAST_INSN;
      end else if ((r_state == ST_IDLE) && (w_next_state == ST_GNT_D)) begin
        r_last_gnt <= LAST_DATA;
      end else begin
        r_last_gnt <= r_last_gnt;
      end
    end
  end

  assign gnt_o = r_gnt;

  // Slave strobe; kept apart from the response mux so the watchdog path has no false loop.
  always_comb begin
    case (r_state)
      ST_GNT_I: w_stb = ci_cyc_i & ci_stb_i;
      ST_GNT_D: w_stb = cd_cyc_i & cd_stb_i;
      default:  w_stb = 1'b0;
    endcase
  end

  assign s_stb_o = w_stb;

  // Request path: the granted master drives the slave port, otherwise everything is quiet.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = 4'b0000;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_cti_o = 3'b000;
    case (r_state)
      ST_GNT_I: begin
        s_adr_o = ci_adr_i;
        s_dat_o = ci_dat_i;
        s_sel_o = ci_sel_i;
        s_we_o  = ci_we_i;
        s_cyc_o = ci_cyc_i;
        s_cti_o = ci_cti_i;
      end
      ST_GNT_D: begin
        s_adr_o = cd_adr_i;
        s_dat_o = cd_dat_i;
        s_sel_o = cd_sel_i;
        s_we_o  = cd_we_i;
        s_cyc_o = cd_cyc_i;
        s_cti_o = cd_cti_i;
      end
      default: begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = 4'b0000;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = 3'b000;
      end
    endcase
  end

  // Response path: late slave responses in ABORT fall into the default and are dropped.
  always_comb begin
    ci_ack_o = 1'b0;
    ci_err_o = 1'b0;
    cd_ack_o = 1'b0;
    cd_err_o = 1'b0;
    case (r_state)
      ST_GNT_I: begin
        ci_ack_o = s_ack_i;
        ci_err_o = s_err_i | w_expired;
      end
      ST_GNT_D: begin
        cd_ack_o = s_ack_i;
        cd_err_o = s_err_i | w_expired;
      end
      default: begin
        ci_ack_o = 1'b0;
        ci_err_o = 1'b0;
        cd_ack_o = 1'b0;
        cd_err_o = 1'b0;
      end
    endcase
  end

  assign m_dat_o = s_dat_i;

  assign w_run = w_stb & ~s_ack_i & ~s_err_i;
  assign w_clr = s_ack_i | s_err_i | (w_next_state != r_state);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (w_clr),
    .run     (w_run),
    .expired (w_expired)
  );

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Directed bench for the CPU bus arbiter: expected responses go into a scoreboard queue,
// a negedge monitor pops and compares every ack/err the DUT presents.
module tb_wb_cpu_bus_arbiter;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  localparam logic [3:0] F_CI_ACK = 4'b1000;
  localparam logic [3:0] F_CI_ERR = 4'b0100;
  localparam logic [3:0] F_CD_ACK = 4'b0010;
  localparam logic [3:0] F_CD_ERR = 4'b0001;

  typedef struct packed {
    logic [3:0]  flags;
    logic [1:0]  gnt;
    logic [31:0] dat;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ci_adr_i = 32'h0, cd_adr_i = 32'h0;
  logic [31:0] ci_dat_i = 32'h1234_5678, cd_dat_i = 32'hDEAD_BEEF;
  logic [3:0]  ci_sel_i = 4'h3, cd_sel_i = 4'hF;
  logic        ci_we_i = 1'b0, cd_we_i = 1'b1;
  logic        ci_cyc_i = 1'b0, cd_cyc_i = 1'b0;
  logic        ci_stb_i = 1'b0, cd_stb_i = 1'b0;
  logic [2:0]  ci_cti_i = 3'b000, cd_cti_i = 3'b000;
  logic        ci_ack_o, ci_err_o, cd_ack_o, cd_err_o;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int slave_lat = 1;
  bit slave_on  = 1'b1;
  bit slave_err = 1'b0;
  bit force_ack = 1'b0;
  int wcnt = 0;

  logic [1:0] b_trace [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};

  wb_cpu_bus_arbiter #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .TIMEOUT       (8)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .ci_adr_i (ci_adr_i), .ci_dat_i (ci_dat_i), .ci_sel_i (ci_sel_i), .ci_we_i (ci_we_i),
    .ci_cyc_i (ci_cyc_i), .ci_stb_i (ci_stb_i), .ci_cti_i (ci_cti_i),
    .ci_ack_o (ci_ack_o), .ci_err_o (ci_err_o),
    .cd_adr_i (cd_adr_i), .cd_dat_i (cd_dat_i), .cd_sel_i (cd_sel_i), .cd_we_i (cd_we_i),
    .cd_cyc_i (cd_cyc_i), .cd_stb_i (cd_stb_i), .cd_cti_i (cd_cti_i),
    .cd_ack_o (cd_ack_o), .cd_err_o (cd_err_o),
    .m_dat_o (m_dat_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_cti_o (s_cti_o),
    .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
    .gnt_o (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] f, input logic [1:0] g, input logic [31:0] d);
    exp_t e;
    e.flags = f;
    e.gnt   = g;
    e.dat   = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Slave model: answers a strobe after slave_lat waiting cycles with data = address ^ KEY.
  initial begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #2;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      if (force_ack) begin
        s_ack_i = 1'b1;
        s_dat_i = 32'hBAD0_0000;
      end else if (slave_on && s_cyc_o && s_stb_o) begin
        if (wcnt >= slave_lat) begin
          if (slave_err) s_err_i = 1'b1;
          else s_ack_i = 1'b1;
          s_dat_i = s_adr_o ^ KEY;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [3:0] act;
    exp_t       e;
    forever begin
      @(negedge clk_i);
      act = {ci_ack_o, ci_err_o, cd_ack_o, cd_err_o};
      if (act != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: flags %b with empty queue at %0t", act, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_flags", 32'(act), 32'(e.flags));
          chk("sb_gnt", 32'(gnt_o), 32'(e.gnt));
          if ((e.flags == F_CI_ACK) || (e.flags == F_CD_ACK)) chk("sb_rdata", m_dat_o, e.dat);
        end
      end
    end
  end

  task automatic master_run(input bit d, input logic [31:0] base, input int beats, input bit burst);
    int         n;
    bit         got_err;
    logic [2:0] cti;
    for (int b = 0; b < beats; b++) begin
      cti = burst ? ((b == beats - 1) ? 3'b111 : 3'b010) : 3'b000;
      if (d) begin
        cd_cyc_i = 1'b1; cd_stb_i = 1'b1; cd_adr_i = base + 32'(4 * b); cd_cti_i = cti;
      end else begin
        ci_cyc_i = 1'b1; ci_stb_i = 1'b1; ci_adr_i = base + 32'(4 * b); ci_cti_i = cti;
      end
      n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (!(d ? (cd_ack_o | cd_err_o) : (ci_ack_o | ci_err_o)) && (n < 100));
      got_err = d ? cd_err_o : ci_err_o;
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL master_wait: master %0d beat %0d got no response, required ack/err", d, b);
      end
      @(posedge clk_i);
      #1;
      if (got_err) break;
    end
    if (d) begin
      cd_cyc_i = 1'b0; cd_stb_i = 1'b0;
    end else begin
      ci_cyc_i = 1'b0; ci_stb_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    // Reset state, with a master already requesting.
    ci_cyc_i = 1'b1;
    ci_stb_i = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("rst_ackerr", 32'({ci_ack_o, ci_err_o, cd_ack_o, cd_err_o}), 32'h0);
    tick();
    chk("rst_hold_gnt", 32'(gnt_o), 32'h0);
    ci_cyc_i = 1'b0;
    ci_stb_i = 1'b0;
    tick();
    rst_i = 1'b0;

    // Tie after reset: data first, one idle cycle, then instruction.
    slave_lat = 1;
    push(F_CD_ACK, 2'b10, 32'h200 ^ KEY);
    push(F_CI_ACK, 2'b01, 32'h300 ^ KEY);
    fork
      master_run(1'b1, 32'h200, 1, 1'b0);
      master_run(1'b0, 32'h300, 1, 1'b0);
      begin
        for (int k = 0; k < 9; k++) begin
          @(negedge clk_i);
          chk("tie_gnt_trace", 32'(gnt_o), 32'(b_trace[k]));
          if (k == 1) begin
            chk("tie_s_dat", s_dat_o, 32'hDEAD_BEEF);
            chk("tie_s_we_sel", 32'({s_we_o, s_sel_o}), 32'h1F);
          end
        end
      end
    join
    tick();

    // Instruction single read, slave waits two cycles.
    slave_lat = 2;
    push(F_CI_ACK, 2'b01, 32'h100 ^ KEY);
    fork
      master_run(1'b0, 32'h100, 1, 1'b0);
      begin
        tick();
        chk("single_gnt", 32'(gnt_o), 32'h1);
        chk("single_s_adr", s_adr_o, 32'h100);
        chk("single_s_ctrl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'h63);
      end
    join
    tick();
    chk("single_idle_gnt", 32'(gnt_o), 32'h0);
    chk("single_idle_cyc", 32'(s_cyc_o), 32'h0);

    // Instruction burst while data waits: all four beats before the data grant.
    slave_lat = 0;
    for (int b = 0; b < 4; b++) push(F_CI_ACK, 2'b01, (32'h400 + 32'(4 * b)) ^ KEY);
    push(F_CD_ACK, 2'b10, 32'h500 ^ KEY);
    fork
      master_run(1'b0, 32'h400, 4, 1'b1);
      begin
        tick();
        master_run(1'b1, 32'h500, 1, 1'b0);
      end
      begin
        repeat (2) @(negedge clk_i);
        chk("burst_cti_first", 32'(s_cti_o), 32'h2);
        repeat (3) @(negedge clk_i);
        chk("burst_cti_last", 32'(s_cti_o), 32'h7);
      end
    join
    tick();

    // Master drops cyc mid-transfer: slave cyc follows in the same cycle.
    slave_on = 1'b0;
    ci_adr_i = 32'h680;
    ci_cti_i = 3'b000;
    ci_cyc_i = 1'b1;
    ci_stb_i = 1'b1;
    tick();
    tick();
    ci_cyc_i = 1'b0;
    ci_stb_i = 1'b0;
    #1;
    chk("drop_s_cyc", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("drop_gnt_held", 32'(gnt_o), 32'h1);
    tick();
    tick();
    chk("drop_idle_gnt", 32'(gnt_o), 32'h0);

    // Timeout with TIMEOUT=8: single err pulse seven cycles after grant, then abort.
    push(F_CI_ERR, 2'b01, 32'h0);
    ci_adr_i = 32'h600;
    ci_cyc_i = 1'b1;
    ci_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ci_err_o && (n < 50));
    chk("timeout_latency", 32'(n), 32'd9);
    tick();
    chk("abort_gnt", 32'(gnt_o), 32'h3);
    chk("abort_s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    force_ack = 1'b1;
    @(negedge clk_i);
    chk("abort_late_ack", 32'({ci_ack_o, ci_err_o}), 32'h0);
    tick();
    force_ack = 1'b0;
    ci_cyc_i = 1'b0;
    ci_stb_i = 1'b0;
    tick();
    tick();
    chk("abort_exit_gnt", 32'(gnt_o), 32'h0);
    slave_on = 1'b1;

    // Slave error routed to the data master only.
    slave_lat = 1;
    slave_err = 1'b1;
    push(F_CD_ERR, 2'b10, 32'h0);
    master_run(1'b1, 32'h700, 1, 1'b0);
    slave_err = 1'b0;
    tick();

    // Reset in the middle of a burst: silent abort, then normal arbitration.
    slave_lat = 2;
    ci_adr_i = 32'h800;
    ci_cti_i = 3'b010;
    ci_cyc_i = 1'b1;
    ci_stb_i = 1'b1;
    tick();
    tick();
    chk("mid_gnt", 32'(gnt_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
    chk("mid_rst_s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("mid_rst_ackerr", 32'({ci_ack_o, ci_err_o, cd_ack_o, cd_err_o}), 32'h0);
    tick();
    ci_cyc_i = 1'b0;
    ci_stb_i = 1'b0;
    ci_cti_i = 3'b000;
    tick();
    rst_i = 1'b0;
    tick();
    slave_lat = 1;
    push(F_CD_ACK, 2'b10, 32'hA00 ^ KEY);
    push(F_CI_ACK, 2'b01, 32'h900 ^ KEY);
    fork
      master_run(1'b1, 32'hA00, 1, 1'b0);
      master_run(1'b0, 32'h900, 1, 1'b0);
    join

    repeat (5) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
